// File: rtl/multdiv_iter.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and divide (restoring on magnitudes).
// One shared 33-bit adder/subtractor serves every iteration; the result is registered 33 cycles after start.
module multdiv_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [32:0] hi_q;      // MULT: Booth accumulator; DIV: partial remainder in [31:0]
    logic [31:0] lo_q;      // MULT: multiplier shifting out; DIV: dividend in / quotient out
    logic [31:0] m_q;       // MULT: multiplicand; DIV: divisor magnitude
    logic        booth_q;
    logic        is_div_q;
    logic        neg_q;
    logic        dz_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        rdy_q;

    logic        start;
    logic [31:0] mag_a, mag_b;
    logic [32:0] add_a, add_b, add_sum;
    logic        add_sub;
    logic [32:0] acc_d;
    logic [32:0] hi_d;
    logic [31:0] lo_d;

    assign start = ctrl_MULT | ctrl_DIV;
    assign mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // Shared adder: Booth add/sub, restoring trial subtract, or final quotient negation.
    always_comb begin
        add_a   = hi_q;
        add_b   = {m_q[31], m_q};
        add_sub = 1'b0;
        case (state_q)
            S_MULT: add_sub = lo_q[0] & ~booth_q;
            S_DIV: begin
                add_a   = {hi_q[31:0], lo_q[31]};
                add_b   = {1'b0, m_q};
                add_sub = 1'b1;
            end
            S_DONE: begin
                add_a   = 33'd0;
                add_b   = {1'b0, lo_q};
                add_sub = 1'b1;
            end
            default: ;
        endcase
        add_sum = add_a + (add_sub ? ~add_b : add_b) + {32'd0, add_sub};
    end

    always_comb begin
        acc_d = (lo_q[0] ^ booth_q) ? add_sum : hi_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (state_q == S_MULT) begin
            hi_d = {acc_d[32], acc_d[32:1]};
            lo_d = {acc_d[0], lo_q[31:1]};
        end else if (state_q == S_DIV) begin
            // remainder < divisor <= 2^31, so hi_q[31] is always clear here
            hi_d = add_sum[32] ? {1'b0, hi_q[30:0], lo_q[31]} : {1'b0, add_sum[31:0]};
            lo_d = {lo_q[30:0], ~add_sum[32]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            hi_q     <= 33'd0;
            lo_q     <= 32'd0;
            m_q      <= 32'd0;
            booth_q  <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (start) begin
                cnt_q    <= 5'd0;
                hi_q     <= 33'd0;
                booth_q  <= 1'b0;
                is_div_q <= ~ctrl_MULT;
                neg_q    <= data_operandA[31] ^ data_operandB[31];
                dz_q     <= (data_operandB == 32'd0);
                if (ctrl_MULT) begin
                    state_q <= S_MULT;
                    lo_q    <= data_operandB;
                    m_q     <= data_operandA;
                end else begin
                    state_q <= S_DIV;
                    lo_q    <= mag_a;
                    m_q     <= mag_b;
                end
            end else begin
                case (state_q)
                    S_MULT, S_DIV: begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        booth_q <= lo_q[0];
                        cnt_q   <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) state_q <= S_DONE;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        cnt_q   <= 5'd0;
                        rdy_q   <= 1'b1;
                        if (!is_div_q) begin
                            result_q <= lo_q;
                            exc_q    <= (hi_q[31:0] != {32{lo_q[31]}});
                        end else if (dz_q) begin
                            result_q <= 32'd0;
                            exc_q    <= 1'b1;
                        end else begin
                            // a positive quotient of 2^31 only arises from 0x80000000 / -1
                            result_q <= neg_q ? add_sum[31:0] : lo_q;
                            exc_q    <= ~neg_q & lo_q[31];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule
